// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, branch types and exception codes used by
// the ALU and its execute-stage output register.
package alu_pkg;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1111;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } br_type_e;

  localparam logic [4:0] EXC_OV = 5'd12;

  // Reserved branch encoding resolves as not-taken.
  function automatic logic branch_taken(input logic [1:0] br_type, input logic zero);
    logic taken;
    case (br_type)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_ex_stage_skid_buf.sv
// Generic 2-entry valid/ready buffer: a main entry driving the outputs and one
// skid entry absorbing the beat that arrives while the consumer stalls.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_v_r, skid_v_r, in_ready_r;
  logic [W-1:0] main_d_r, skid_d_r;
  logic         accept_s, drain_s;
  logic         main_v_s, skid_v_s;
  logic         main_load_s, main_from_skid_s, skid_load_s;

  // Next occupancy and load selects; flush overrides every other event.
  always_comb begin
    accept_s         = in_valid & in_ready_r & ~flush;
    drain_s          = main_v_r & out_ready;
    main_v_s         = main_v_r;
    skid_v_s         = skid_v_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      main_v_s = 1'b0;
      skid_v_s = 1'b0;
    end else if (drain_s && skid_v_r) begin
      main_load_s      = 1'b1;
      main_from_skid_s = 1'b1;
      main_v_s         = 1'b1;
      skid_load_s      = accept_s;
      skid_v_s         = accept_s;
    end else if (drain_s || !main_v_r) begin
      main_load_s = accept_s;
      main_v_s    = accept_s;
    end else begin
      skid_load_s = accept_s;
      skid_v_s    = skid_v_r | accept_s;
    end
  end

  // Valid bits and the registered ready, which looks at next-state skid occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_r   <= 1'b0;
      skid_v_r   <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      main_v_r   <= main_v_s;
      skid_v_r   <= skid_v_s;
      in_ready_r <= ~skid_v_s;
    end
  end

  // Payload storage; empty entries simply keep their last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_d_r <= {W{1'b0}};
      skid_d_r <= {W{1'b0}};
    end else begin
      if (main_load_s) begin
        main_d_r <= main_from_skid_s ? skid_d_r : in_data;
      end else begin
        main_d_r <= main_d_r;
      end
      if (skid_load_s) begin
        skid_d_r <= in_data;
      end else begin
        skid_d_r <= skid_d_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_v_r;
  assign out_data  = main_d_r;

endmodule

// File: rtl/alu_ex_stage.sv
// Execute-stage output register behind the ALU: resolves beq/bne, raises the
// overflow exception, gates register writes and buffers results for memory.
module alu_ex_stage #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] EXC_OV = alu_pkg::EXC_OV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluc,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_negative,
  input  logic             in_overflow,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [4:0]       in_rd,
  input  logic             in_wen,
  input  logic             in_ov_trap,
  input  logic [1:0]       in_br_type,
  input  logic [WIDTH-1:0] in_br_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             out_exc,
  output logic [4:0]       out_exc_code,
  output logic [WIDTH-1:0] out_epc,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);
  import alu_pkg::*;

  localparam int PW = 2 * WIDTH + 12;

  logic             exc_s, taken_s, eff_wen_s, accept_s;
  logic [4:0]       exc_code_s;
  logic [WIDTH-1:0] epc_s;
  logic [PW-1:0]    payload_s, out_data_s;
  logic             redirect_valid_r;
  logic [WIDTH-1:0] redirect_pc_r;
  logic             unused_s;

  // Opcode and the remaining flags only matter for trace, not for this stage.
  assign unused_s = ^{in_aluc, in_carry, in_negative};

  assign accept_s   = in_valid & in_ready & ~flush;
  assign exc_s      = in_ov_trap & in_overflow;
  assign taken_s    = branch_taken(in_br_type, in_zero) & ~exc_s;
  assign eff_wen_s  = in_wen & ~exc_s & (in_rd != 5'd0);
  assign exc_code_s = exc_s ? EXC_OV : 5'd0;
  assign epc_s      = exc_s ? in_pc : {WIDTH{1'b0}};
  assign payload_s  = {in_r, in_rd, eff_wen_s, exc_s, exc_code_s, epc_s};

  skid_buf #(.W(PW)) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payload_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data_s)
  );

  assign {out_r, out_rd, out_wen, out_exc, out_exc_code, out_epc} = out_data_s;

  // Taken-branch redirect bypasses the buffer so fetch hears it after one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {WIDTH{1'b0}};
    end else begin
      redirect_valid_r <= accept_s & taken_s;
      if (accept_s && taken_s) begin
        redirect_pc_r <= in_br_target;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Randomised self-checking bench for alu_ex_stage: a queue-based model of the
// stage is checked on every falling edge, plus directed literal scenarios.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_aluc;
  logic [31:0] in_r, in_pc, in_br_target;
  logic        in_zero, in_carry, in_negative, in_overflow;
  logic [4:0]  in_rd;
  logic        in_wen, in_ov_trap;
  logic [1:0]  in_br_type;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_r, out_epc, redirect_pc;
  logic [4:0]  out_rd, out_exc_code;
  logic        out_wen, out_exc, redirect_valid;

  int n_cmp = 0;
  int n_err = 0;

  alu_ex_stage #(.WIDTH(32), .EXC_OV(5'd12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluc(in_aluc), .in_r(in_r), .in_zero(in_zero), .in_carry(in_carry),
    .in_negative(in_negative), .in_overflow(in_overflow), .in_pc(in_pc),
    .in_rd(in_rd), .in_wen(in_wen), .in_ov_trap(in_ov_trap),
    .in_br_type(in_br_type), .in_br_target(in_br_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc),
    .out_exc_code(out_exc_code), .out_epc(out_epc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        wen;
    logic        exc;
    logic [31:0] epc;
  } ent_t;

  ent_t        q[$];
  logic        m_redir = 1'b0;
  logic [31:0] m_redir_pc = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue holding at most two accepted results.
  always @(posedge clk or negedge rst_n) begin
    bit   acc, drn, exc, taken;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_redir = 1'b0;
    end else if (flush) begin
      q.delete();
      m_redir = 1'b0;
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      m_redir = 1'b0;
      if (acc) begin
        exc   = in_ov_trap && in_overflow;
        taken = !exc && ((in_br_type == 2'd1 && in_zero) || (in_br_type == 2'd2 && !in_zero));
        e.r   = in_r;
        e.rd  = in_rd;
        e.wen = in_wen && !exc && (in_rd != 5'd0);
        e.exc = exc;
        e.epc = in_pc;
        q.push_back(e);
        if (taken) begin
          m_redir    = 1'b1;
          m_redir_pc = in_br_target;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_r", out_r, q[0].r);
        chk("out_rd", 32'(out_rd), 32'(q[0].rd));
        chk("out_wen", 32'(out_wen), 32'(q[0].wen));
        chk("out_exc", 32'(out_exc), 32'(q[0].exc));
        chk("out_exc_code", 32'(out_exc_code), q[0].exc ? 32'd12 : 32'd0);
        if (q[0].exc) chk("out_epc", out_epc, q[0].epc);
      end
      chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
      if (m_redir) chk("redirect_pc", redirect_pc, m_redir_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rd,
                       input logic wen, input logic ov, input logic trap,
                       input logic [1:0] br, input logic zero,
                       input logic [31:0] pc, input logic [31:0] tgt);
    in_valid     = v;
    in_r         = r;
    in_rd        = rd;
    in_wen       = wen;
    in_overflow  = ov;
    in_ov_trap   = trap;
    in_br_type   = br;
    in_zero      = zero;
    in_pc        = pc;
    in_br_target = tgt;
    in_aluc      = 4'($urandom_range(0, 15));
    in_carry     = 1'($urandom_range(0, 1));
    in_negative  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rand_drive(input int ready_pct, input int flush_pct);
    drive(1'($urandom_range(0, 3) != 0), $urandom,
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom, $urandom);
    out_ready = ($urandom_range(0, 99) < ready_pct);
    flush     = ($urandom_range(0, 99) < flush_pct);
  endtask

  task automatic check_reset_vals();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst out_r", out_r, 32'd0);
    chk("rst out_rd", 32'(out_rd), 32'd0);
    chk("rst out_wen", 32'(out_wen), 32'd0);
    chk("rst out_exc", 32'(out_exc), 32'd0);
    chk("rst out_exc_code", 32'(out_exc_code), 32'd0);
    chk("rst out_epc", out_epc, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    #12;
    check_reset_vals();
    rst_n = 1'b1;
    step();

    // Add overflow trap
    drive(1'b1, 32'h8000_0000, 5'd8, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0040_0010, 32'd0);
    step();
    idle();
    chk("ov out_valid", 32'(out_valid), 32'd1);
    chk("ov out_exc", 32'(out_exc), 32'd1);
    chk("ov out_exc_code", 32'(out_exc_code), 32'd12);
    chk("ov out_epc", out_epc, 32'h0040_0010);
    chk("ov out_wen", 32'(out_wen), 32'd0);
    step();

    // beq taken, then bne not taken
    drive(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0040_0020, 32'h0040_0100);
    step();
    chk("beq redirect_valid", 32'(redirect_valid), 32'd1);
    chk("beq redirect_pc", redirect_pc, 32'h0040_0100);
    drive(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'h0040_0024, 32'h0040_0200);
    step();
    idle();
    chk("bne redirect_valid", 32'(redirect_valid), 32'd0);
    step();
    chk("pulse width", 32'(redirect_valid), 32'd0);

    // Write to r0 is suppressed
    drive(1'b1, 32'h0000_1234, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0040_0030, 32'd0);
    step();
    idle();
    chk("rd0 out_wen", 32'(out_wen), 32'd0);
    chk("rd0 out_r", out_r, 32'h0000_1234);
    step();

    // Back-pressure with A, B, C
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 5'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    chk("bp in_ready after A", 32'(in_ready), 32'd1);
    drive(1'b1, 32'hBBBB_0002, 5'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    chk("bp in_ready after B", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hCCCC_0003, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    chk("bp hold in_ready", 32'(in_ready), 32'd0);
    chk("bp hold out_r", out_r, 32'hAAAA_0001);
    out_ready = 1'b1;
    step();
    chk("bp second out_r", out_r, 32'hBBBB_0002);
    step();
    idle();
    chk("bp third out_r", out_r, 32'hCCCC_0003);
    chk("bp third out_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp drained", 32'(out_valid), 32'd0);

    // Flush a full buffer while a taken branch is presented
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_0001, 5'd4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    drive(1'b1, 32'h1111_0002, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    drive(1'b1, 32'h2222_0003, 5'd6, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0, 32'h0040_0300);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    chk("flush redirect", 32'(redirect_valid), 32'd0);
    step();
    chk("flush dropped", 32'(out_valid), 32'd0);

    // Random traffic in phases of varying back-pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        rand_drive((ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 15 : 70, (ph == 3) ? 8 : 3);
        step();
      end
    end

    // Asynchronous reset mid-stream with a full buffer
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h3333_0001, 5'd7, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0, 32'h0040_0400);
    step();
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    drive(1'b1, 32'h4444_0001, 5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    step();
    idle();
    chk("post-reset out_valid", 32'(out_valid), 32'd1);
    chk("post-reset out_r", out_r, 32'h4444_0001);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
